mem_access_unit: RTL and testbench
==================================

// Module: mem_access_unit
// PURPOSE
//  Parametrised, multi-cycle memory access controller between the datapath (MAR/MDR side) and
//  the byte-addressed RAM's MFA/MFC handshake. Replaces ad-hoc control-unit sequencing of ramMFA/ramRW.
//  Adds per-request size, sign/zero extension, alignment checking and an MFC timeout.
//  Reports completion or fault back to the control unit.
// PARAMETERS
//  DATA_W   32  data width; 32 or 64 (64 enables size 2'b11 = doubleword)
//  ADDR_W   9   RAM byte-address width
//  TIMEOUT  64  max cycles waiting for MFC before fault; 0 disables timeout
// PORTS
//  Clk        in   1       system clock, rising edge
//  reset      in   1       asynchronous, active-low reset
//  req        in   1       access request; sampled only in IDLE
//  rw         in   1       1 = read, 0 = write (RAM convention)
//  size       in   2       00 byte, 01 half, 10 word, 11 dword (DATA_W=64 only)
//  sign_ext   in   1       reads: 1 = sign-extend, 0 = zero-extend
//  addr       in   ADDR_W  byte address
//  wdata      in   DATA_W  write data, right-justified
//  busy       out  1       high from acceptance until return to IDLE
//  done       out  1       one-cycle pulse: access completed OK
//  fault      out  1       one-cycle pulse: access aborted
//  fault_code out  2       00 none, 01 misaligned, 10 timeout, 11 illegal size; held until next accept
//  rdata      out  DATA_W  formatted read data; held until next completed read
//  mem_mfa    out  1       memory function active to RAM
//  mem_rw     out  1       RAM read/write
//  mem_addr   out  ADDR_W  RAM address
//  mem_size   out  2       RAM dataSize
//  mem_din    out  DATA_W  RAM write data (lanes above size zeroed)
//  mem_mfc    in   1       memory function complete from RAM
//  mem_dout   in   DATA_W  RAM read data, right-justified
// BEHAVIOUR
//  Reset (async, reset=0): state IDLE, all outputs 0, timeout counter 0; mem_mfa drops immediately
//   even mid-access. No done/fault is issued for an aborted access.
//  FSM: IDLE -> CHECK -> ACCESS -> DONE -> RELEASE -> IDLE; CHECK/ACCESS -> FAULT -> RELEASE.
//  IDLE: req=1 latches rw,size,sign_ext,addr,wdata; busy=1 next cycle; go CHECK.
//  CHECK (1 cyc): size 11 with DATA_W=32 -> code 11; addr not multiple of (1<<size) -> code 01;
//   either -> FAULT. Else -> ACCESS. Illegal size takes priority over misalignment.
//  ACCESS: mem_mfa=1, mem_* driven from latched request, stable throughout. Counter increments per
//   cycle. mem_mfc=1 sampled -> capture/format mem_dout (reads), go DONE. If TIMEOUT!=0 and counter
//   reaches TIMEOUT with no MFC -> code 10, FAULT. MFC on the same edge as timeout: MFC wins.
//  DONE: done=1 (1 cyc), mem_mfa=0, rdata updated same cycle done rises -> RELEASE.
//  FAULT: fault=1 (1 cyc), mem_mfa=0; rdata unchanged -> RELEASE.
//  RELEASE: wait until mem_mfc=0, then IDLE (busy=0). Prevents a stale MFC completing next request.
//  Best-case latency req->done: 4 cycles with MFC returned on first ACCESS cycle.
//  Format: byte uses [7:0], half [15:0], word [31:0], dword [63:0]; upper bits = sign bit of lane
//   if sign_ext&rw else 0. Writes ignore sign_ext.
//  req while busy is ignored (not queued); control unit must hold req until busy seen or re-issue.
// STRUCTURE
//  mem_access_pkg: state encodings, SIZE_* and FAULT_* localparams, size-to-bytes function.
//  Sub-module mem_data_formatter: combinational lane select + sign/zero extend, shared by read
//   capture and write masking (DATA_W parameter). FSM, counter and latches stay in top.
// TESTING
//  Word read addr 0x010, sign_ext=0, MFC after 3 ACCESS cycles, dout=0xDEADBEEF -> done, rdata 0xDEADBEEF.
//  Byte read addr 0x013, sign_ext=1, dout=0x00000085 -> rdata 0xFFFFFF85; sign_ext=0 -> 0x00000085.
//  Half write addr 0x021 -> fault code 01 after CHECK, mem_mfa never asserted.
//  Word write addr 0x040, wdata 0x12345678, MFC never -> fault code 10 after exactly TIMEOUT cycles.
//  MFC held high 5 cycles after DONE -> stays RELEASE, busy=1, new req ignored until MFC=0.
//  reset=0 during ACCESS -> mem_mfa=0 same cycle, no done/fault pulse, busy=0.

Source files
------------

// File: rtl/mem_access_pkg.sv
// Shared encodings for the memory access unit: FSM states, request sizes,
// fault codes and a size-to-byte-count helper.
package mem_access_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CHECK   = 3'd1,
    ST_ACCESS  = 3'd2,
    ST_DONE    = 3'd3,
    ST_FAULT   = 3'd4,
    ST_RELEASE = 3'd5
  } state_e;

  localparam logic [1:0] SIZE_BYTE  = 2'b00;
  localparam logic [1:0] SIZE_HALF  = 2'b01;
  localparam logic [1:0] SIZE_WORD  = 2'b10;
  localparam logic [1:0] SIZE_DWORD = 2'b11;

  localparam logic [1:0] FAULT_NONE     = 2'b00;
  localparam logic [1:0] FAULT_MISALIGN = 2'b01;
  localparam logic [1:0] FAULT_TIMEOUT  = 2'b10;
  localparam logic [1:0] FAULT_SIZE     = 2'b11;

  // Number of bytes moved by an access of the given size code.
  function automatic int unsigned size_bytes(input logic [1:0] sz);
    return 32'd1 << sz;
  endfunction

endpackage

// File: rtl/mem_data_formatter.sv
// Combinational lane select plus sign/zero extension of right-justified data.
// Ports:
//   din    : raw right-justified data
//   size   : 00 byte, 01 half, 10 word, 11 dword (full width)
//   sext   : 1 = replicate the lane's top bit upward, 0 = zero-fill
//   data_c : formatted data (combinational)
module mem_data_formatter
  import mem_access_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic [DATA_W-1:0] din,
  input  logic [1:0]        size,
  input  logic              sext,
  output logic [DATA_W-1:0] data_c
);

  logic [DATA_W-1:0] ext_b;
  logic [DATA_W-1:0] ext_h;
  logic [DATA_W-1:0] ext_w;

  assign ext_b = {{(DATA_W-8){sext & din[7]}}, din[7:0]};
  assign ext_h = {{(DATA_W-16){sext & din[15]}}, din[15:0]};

  // A word only needs extending when the datapath is wider than 32 bits.
  if (DATA_W > 32) begin : g_wide
    assign ext_w = {{(DATA_W-32){sext & din[31]}}, din[31:0]};
  end else begin : g_narrow
    assign ext_w = din;
  end

  // Size select; dword (or an illegal dword on a 32-bit build) passes through.
  always_comb begin
    data_c = din;
    case (size)
      SIZE_BYTE: data_c = ext_b;
      SIZE_HALF: data_c = ext_h;
      SIZE_WORD: data_c = ext_w;
      default:   data_c = din;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Multi-cycle memory access controller between the datapath and a RAM using
// an MFA/MFC handshake. Latches one request, checks size and alignment,
// runs the handshake with an optional MFC timeout, formats read data and
// reports done or fault. Waits for MFC to drop before accepting new work.
// Ports:
//   Clk, reset        : clock (rising edge), asynchronous active-low reset
//   req/rw/size/sign_ext/addr/wdata : request from control unit (sampled in IDLE)
//   busy/done/fault/fault_code/rdata : status and read data to control unit
//   mem_mfa/mem_rw/mem_addr/mem_size/mem_din : RAM command side
//   mem_mfc/mem_dout  : RAM completion and read data
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 9,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic              Clk,
  input  logic              reset,
  input  logic              req,
  input  logic              rw,
  input  logic [1:0]        size,
  input  logic              sign_ext,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              done,
  output logic              fault,
  output logic [1:0]        fault_code,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_mfa,
  output logic              mem_rw,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [1:0]        mem_size,
  output logic [DATA_W-1:0] mem_din,
  input  logic              mem_mfc,
  input  logic [DATA_W-1:0] mem_dout
);

  localparam int unsigned      CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam bit               DWORD_OK = (DATA_W == 64);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              sext_q, sext_d;
  logic              busy_d, done_d, fault_d, mem_mfa_d, mem_rw_d;
  logic [1:0]        fault_code_d, mem_size_d;
  logic [DATA_W-1:0] rdata_d, mem_din_d;
  logic [ADDR_W-1:0] mem_addr_d;

  logic [DATA_W-1:0] rd_fmt_c;
  logic [DATA_W-1:0] wr_fmt_c;
  logic              misaligned_c;
  logic              illegal_size_c;

  // Read path formats the RAM data with the latched request attributes.
  mem_data_formatter #(.DATA_W(DATA_W)) u_rd_fmt (
    .din    (mem_dout),
    .size   (mem_size),
    .sext   (sext_q),
    .data_c (rd_fmt_c)
  );

  // Write path zeroes lanes above the requested size at acceptance time.
  mem_data_formatter #(.DATA_W(DATA_W)) u_wr_fmt (
    .din    (wdata),
    .size   (size),
    .sext   (1'b0),
    .data_c (wr_fmt_c)
  );

  assign misaligned_c   = |(mem_addr & ADDR_W'(size_bytes(mem_size) - 32'd1));
  assign illegal_size_c = (mem_size == SIZE_DWORD) && !DWORD_OK;

  // State and output registers.
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      sext_q     <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      fault      <= 1'b0;
      fault_code <= FAULT_NONE;
      rdata      <= '0;
      mem_mfa    <= 1'b0;
      mem_rw     <= 1'b0;
      mem_addr   <= '0;
      mem_size   <= '0;
      mem_din    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sext_q     <= sext_d;
      busy       <= busy_d;
      done       <= done_d;
      fault      <= fault_d;
      fault_code <= fault_code_d;
      rdata      <= rdata_d;
      mem_mfa    <= mem_mfa_d;
      mem_rw     <= mem_rw_d;
      mem_addr   <= mem_addr_d;
      mem_size   <= mem_size_d;
      mem_din    <= mem_din_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    sext_d       = sext_q;
    fault_code_d = fault_code;
    rdata_d      = rdata;
    mem_rw_d     = mem_rw;
    mem_addr_d   = mem_addr;
    mem_size_d   = mem_size;
    mem_din_d    = mem_din;

    case (state_q)
      ST_IDLE: begin
        if (req) begin
          state_d      = ST_CHECK;
          sext_d       = sign_ext;
          mem_rw_d     = rw;
          mem_addr_d   = addr;
          mem_size_d   = size;
          mem_din_d    = wr_fmt_c;
          fault_code_d = FAULT_NONE;
        end
      end
      ST_CHECK: begin
        // Illegal size outranks misalignment.
        if (illegal_size_c) begin
          state_d      = ST_FAULT;
          fault_code_d = FAULT_SIZE;
        end else if (misaligned_c) begin
          state_d      = ST_FAULT;
          fault_code_d = FAULT_MISALIGN;
        end else begin
          state_d = ST_ACCESS;
          cnt_d   = '0;
        end
      end
      ST_ACCESS: begin
        // MFC is checked first so a completion on the timeout edge still wins.
        if (mem_mfc) begin
          state_d = ST_DONE;
          if (mem_rw) begin
            rdata_d = rd_fmt_c;
          end
        end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
          state_d      = ST_FAULT;
          fault_code_d = FAULT_TIMEOUT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE, ST_FAULT: begin
        state_d = ST_RELEASE;
      end
      ST_RELEASE: begin
        // Hold off until the RAM drops MFC so it cannot complete the next request.
        if (!mem_mfc) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d    = (state_d != ST_IDLE);
    done_d    = (state_d == ST_DONE);
    fault_d   = (state_d == ST_FAULT);
    mem_mfa_d = (state_d == ST_ACCESS);
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit (DATA_W=32, ADDR_W=9, TIMEOUT=16).
module tb_mem_access_unit;

  localparam int unsigned TMO = 16;
  localparam int          NV  = 13;

  logic        Clk;
  logic        reset;
  logic        req;
  logic        rw;
  logic [1:0]  size;
  logic        sign_ext;
  logic [8:0]  addr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        fault;
  logic [1:0]  fault_code;
  logic [31:0] rdata;
  logic        mem_mfa;
  logic        mem_rw;
  logic [8:0]  mem_addr;
  logic [1:0]  mem_size;
  logic [31:0] mem_din;
  logic        mem_mfc;
  logic [31:0] mem_dout;

  mem_access_unit #(.DATA_W(32), .ADDR_W(9), .TIMEOUT(TMO)) dut (
    .Clk        (Clk),
    .reset      (reset),
    .req        (req),
    .rw         (rw),
    .size       (size),
    .sign_ext   (sign_ext),
    .addr       (addr),
    .wdata      (wdata),
    .busy       (busy),
    .done       (done),
    .fault      (fault),
    .fault_code (fault_code),
    .rdata      (rdata),
    .mem_mfa    (mem_mfa),
    .mem_rw     (mem_rw),
    .mem_addr   (mem_addr),
    .mem_size   (mem_size),
    .mem_din    (mem_din),
    .mem_mfc    (mem_mfc),
    .mem_dout   (mem_dout)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic        rw;
    logic [1:0]  size;
    logic        sext;
    logic [8:0]  addr;
    logic [31:0] wdata;
    logic [31:0] dout;
    int          delay;      // ACCESS cycle on which MFC rises, 0 = never
    logic        exp_done;
    logic [1:0]  exp_code;
    logic [31:0] exp_rdata;  // reads only
    logic [31:0] exp_din;    // writes only
    int          exp_mfa;    // cycles mem_mfa is high
  } vec_t;

  vec_t vecs [NV];
  int   n_tests;
  int   n_fail;

  function automatic vec_t mk(input logic r, input logic [1:0] sz, input logic sx,
                              input logic [8:0] a, input logic [31:0] wd, input logic [31:0] dt,
                              input int dl, input logic ed, input logic [1:0] ec,
                              input logic [31:0] er, input logic [31:0] edin, input int em);
    vec_t v;
    v.rw = r; v.size = sz; v.sext = sx; v.addr = a; v.wdata = wd; v.dout = dt;
    v.delay = dl; v.exp_done = ed; v.exp_code = ec; v.exp_rdata = er;
    v.exp_din = edin; v.exp_mfa = em;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  initial begin
    vec_t        v;
    logic [31:0] model_rdata;
    logic        got_done, got_fault;
    logic [31:0] seen_din;
    logic [8:0]  seen_addr;
    logic        seen_rw;
    logic [1:0]  seen_size;
    int          lat, mfa_n, exp_lat;

    n_tests = 0; n_fail = 0;
    reset = 1'b0; req = 1'b0; rw = 1'b0; size = 2'b00; sign_ext = 1'b0;
    addr = '0; wdata = '0; mem_mfc = 1'b0; mem_dout = '0;
    model_rdata = '0;

    //         rw    size   sx    addr    wdata         dout          dly  done  code   rdata         din           mfa
    vecs[0]  = mk(1'b1, 2'b10, 1'b0, 9'h010, 32'h0,        32'hDEADBEEF, 3,   1'b1, 2'b00, 32'hDEADBEEF, 32'h0,        3);
    vecs[1]  = mk(1'b1, 2'b00, 1'b1, 9'h013, 32'h0,        32'h00000085, 1,   1'b1, 2'b00, 32'hFFFFFF85, 32'h0,        1);
    vecs[2]  = mk(1'b1, 2'b00, 1'b0, 9'h013, 32'h0,        32'h00000085, 1,   1'b1, 2'b00, 32'h00000085, 32'h0,        1);
    vecs[3]  = mk(1'b1, 2'b01, 1'b1, 9'h022, 32'h0,        32'h12348001, 2,   1'b1, 2'b00, 32'hFFFF8001, 32'h0,        2);
    vecs[4]  = mk(1'b1, 2'b01, 1'b1, 9'h022, 32'h0,        32'hABCD7FFE, 1,   1'b1, 2'b00, 32'h00007FFE, 32'h0,        1);
    vecs[5]  = mk(1'b0, 2'b00, 1'b1, 9'h005, 32'hCAFEBABE, 32'hFFFFFFFF, 2,   1'b1, 2'b00, 32'h0,        32'h000000BE, 2);
    vecs[6]  = mk(1'b0, 2'b01, 1'b0, 9'h021, 32'hFFFF1234, 32'h0,        1,   1'b0, 2'b01, 32'h0,        32'h0,        0);
    vecs[7]  = mk(1'b0, 2'b10, 1'b0, 9'h040, 32'h12345678, 32'h0,        0,   1'b0, 2'b10, 32'h0,        32'h12345678, TMO);
    vecs[8]  = mk(1'b1, 2'b11, 1'b0, 9'h001, 32'h0,        32'h0,        1,   1'b0, 2'b11, 32'h0,        32'h0,        0);
    vecs[9]  = mk(1'b1, 2'b10, 1'b0, 9'h002, 32'h0,        32'h0,        1,   1'b0, 2'b01, 32'h0,        32'h0,        0);
    vecs[10] = mk(1'b1, 2'b10, 1'b1, 9'h0FC, 32'h0,        32'h80000000, TMO, 1'b1, 2'b00, 32'h80000000, 32'h0,        TMO);
    vecs[11] = mk(1'b1, 2'b00, 1'b1, 9'h1FF, 32'h0,        32'h0000007F, 1,   1'b1, 2'b00, 32'h0000007F, 32'h0,        1);
    vecs[12] = mk(1'b0, 2'b01, 1'b1, 9'h1FE, 32'h89ABCDEF, 32'h0,        1,   1'b1, 2'b00, 32'h0,        32'h0000CDEF, 1);

    // Reset state
    repeat (2) @(negedge Clk);
    chk("reset busy", 32'(busy), 32'h0);
    chk("reset mem_mfa", 32'(mem_mfa), 32'h0);
    chk("reset done|fault|code", 32'({done, fault, fault_code}), 32'h0);
    chk("reset rdata", rdata, 32'h0);
    chk("reset mem bus", 32'({mem_rw, mem_size, mem_addr}) | mem_din, 32'h0);
    reset = 1'b1;
    @(negedge Clk);
    chk("post-reset busy", 32'(busy), 32'h0);

    // Table-driven accesses
    for (int i = 0; i < NV; i++) begin
      v = vecs[i];
      @(negedge Clk);
      req = 1'b1; rw = v.rw; size = v.size; sign_ext = v.sext; addr = v.addr; wdata = v.wdata;
      @(negedge Clk);
      // Scramble inputs so only latched values can be used.
      req = 1'b0; rw = ~v.rw; size = ~v.size; sign_ext = ~v.sext; addr = ~v.addr; wdata = ~v.wdata;
      chk($sformatf("v%0d busy after accept", i), 32'(busy), 32'h1);
      lat = 2; mfa_n = 0; got_done = 1'b0; got_fault = 1'b0;
      seen_din = '0; seen_addr = '0; seen_rw = 1'b0; seen_size = '0;
      while (!got_done && !got_fault && lat < 100) begin
        if (done) got_done = 1'b1;
        else if (fault) got_fault = 1'b1;
        else begin
          if (mem_mfa) begin
            mfa_n++;
            seen_din = mem_din; seen_addr = mem_addr; seen_rw = mem_rw; seen_size = mem_size;
            if (mfa_n == v.delay) begin
              mem_mfc = 1'b1;
              mem_dout = v.dout;
            end
          end
          @(negedge Clk);
          lat++;
        end
      end
      chk($sformatf("v%0d completed", i), 32'(got_done | got_fault), 32'h1);
      chk($sformatf("v%0d done", i), 32'(got_done), 32'(v.exp_done));
      chk($sformatf("v%0d fault", i), 32'(got_fault), 32'(!v.exp_done));
      chk($sformatf("v%0d mfa low at end", i), 32'(mem_mfa), 32'h0);
      chk($sformatf("v%0d mfa cycles", i), mfa_n, v.exp_mfa);
      if (v.exp_done) exp_lat = 3 + v.delay;
      else if (v.exp_code == 2'b10) exp_lat = 3 + int'(TMO);
      else exp_lat = 3;
      chk($sformatf("v%0d latency", i), lat, exp_lat);
      if (v.exp_mfa > 0) begin
        chk($sformatf("v%0d mem_addr", i), 32'(seen_addr), 32'(v.addr));
        chk($sformatf("v%0d mem_rw", i), 32'(seen_rw), 32'(v.rw));
        chk($sformatf("v%0d mem_size", i), 32'(seen_size), 32'(v.size));
        if (!v.rw) chk($sformatf("v%0d mem_din", i), seen_din, v.exp_din);
      end
      if (v.rw && v.exp_done) model_rdata = v.exp_rdata;
      chk($sformatf("v%0d rdata at pulse", i), rdata, model_rdata);
      mem_mfc = 1'b0;
      mem_dout = 32'h5A5A5A5A;
      @(negedge Clk);
      chk($sformatf("v%0d one-cycle pulse", i), 32'({done, fault}), 32'h0);
      for (int k = 0; k < 10 && busy; k++) @(negedge Clk);
      chk($sformatf("v%0d busy released", i), 32'(busy), 32'h0);
      chk($sformatf("v%0d rdata held", i), rdata, model_rdata);
      chk($sformatf("v%0d fault_code", i), 32'(fault_code), 32'(v.exp_code));
    end

    // MFC held after DONE: stay in RELEASE, ignore a new (illegal) request
    @(negedge Clk);
    req = 1'b1; rw = 1'b1; size = 2'b10; sign_ext = 1'b0; addr = 9'h010;
    @(negedge Clk);
    req = 1'b0;
    @(negedge Clk);
    chk("hold mfa", 32'(mem_mfa), 32'h1);
    mem_mfc = 1'b1; mem_dout = 32'h11112222;
    @(negedge Clk);
    chk("hold done", 32'(done), 32'h1);
    chk("hold rdata", rdata, 32'h11112222);
    for (int k = 0; k < 5; k++) begin
      @(negedge Clk);
      if (k == 0) begin
        req = 1'b1; size = 2'b11; addr = 9'h001;
      end
      chk($sformatf("hold busy %0d", k), 32'(busy), 32'h1);
      chk($sformatf("hold quiet %0d", k), 32'({done, fault, mem_mfa}), 32'h0);
    end
    req = 1'b0; mem_mfc = 1'b0;
    @(negedge Clk);
    chk("hold release busy", 32'(busy), 32'h0);
    for (int k = 0; k < 3; k++) begin
      @(negedge Clk);
      chk($sformatf("hold ignored %0d", k), 32'({busy, fault, fault_code}), 32'h0);
    end

    // Asynchronous reset in the middle of ACCESS
    @(negedge Clk);
    req = 1'b1; rw = 1'b1; size = 2'b10; addr = 9'h020;
    @(negedge Clk);
    req = 1'b0;
    @(negedge Clk);
    chk("abort mfa before reset", 32'(mem_mfa), 32'h1);
    @(negedge Clk);
    #2 reset = 1'b0;
    #1;
    chk("abort mfa drops", 32'(mem_mfa), 32'h0);
    chk("abort busy drops", 32'(busy), 32'h0);
    chk("abort rdata cleared", rdata, 32'h0);
    @(negedge Clk);
    reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge Clk);
      chk($sformatf("abort no pulse %0d", k), 32'({busy, done, fault, mem_mfa}), 32'h0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
